cpu_multicycle: RTL and testbench

Parametrised, clocked successor to the 16-bit accumulator cpu. It fetches one instruction per pass from an external instruction memory, executes it with a fetch/execute state machine, and runs variable-latency data-memory accesses through a ready handshake. Data width is generic. The instruction word is a fixed-width opcode followed by an immediate.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/cpu_alu.sv | 48 ++++
 rtl/cpu_multicycle.sv | 170 +++++++++++++++++
 tb/tb_cpu_multicycle.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the multicycle accumulator core: opcodes, FSM state encoding
// and default widths. CPU_MUL_EN enables the MUL opcode.
package cpu_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_OPW   = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_MUL = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for memory-operand instructions. MUL exists only when CPU_MUL_EN
// is defined; otherwise no multiplier is built.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, operand};
  // Top bit of the widened difference is the borrow (a < operand).
  assign diff = {1'b0, a} - {1'b0, operand};

`ifdef CPU_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, operand};
`endif

  always_comb begin
    result = a;
    carry  = 1'b0;
    case (op)
      OPW'(OP_LD):  result = operand;
      OPW'(OP_ADD): {carry, result} = sum;
      OPW'(OP_SUB): {carry, result} = diff;
      OPW'(OP_AND): result = a & operand;
      OPW'(OP_OR):  result = a | operand;
      OPW'(OP_XOR): result = a ^ operand;
`ifdef CPU_MUL_EN
      OPW'(OP_MUL): begin
        result = prod[WIDTH-1:0];
        carry  = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle accumulator core: FETCH/EXEC/MEM/HALT FSM with a data_ready handshake.
// Define CPU_MUL_EN to add the MUL (0xD) memory-operand instruction.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW,
  parameter int IMMW  = WIDTH - OPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction,
  input  logic [WIDTH-1:0] data,
  input  logic             data_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] addr,
  output logic             read,
  output logic             write,
  output logic             halted
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             halted_q, halted_d;

  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             op_sets_c;

  assign op     = ir_q[WIDTH-1:IMMW];
  assign imm    = WIDTH'(ir_q[IMMW-1:0]);
  assign pc_inc = pc_q + WIDTH'(1);

`ifdef CPU_MUL_EN
  assign op_sets_c = (op == OPW'(OP_ADD)) || (op == OPW'(OP_SUB)) || (op == OPW'(OP_MUL));
`else
  assign op_sets_c = (op == OPW'(OP_ADD)) || (op == OPW'(OP_SUB));
`endif

  cpu_alu #(
    .WIDTH(WIDTH),
    .OPW  (OPW)
  ) u_alu (
    .op     (op),
    .a      (a_q),
    .operand(data),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    ir_d     = ir_q;
    addr_d   = addr_q;
    z_d      = z_q;
    c_d      = c_q;
    read_d   = read_q;
    write_d  = write_q;
    halted_d = halted_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = instruction;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (op)
          OPW'(OP_LDI): begin
            a_d = imm;
            z_d = (imm == '0);
          end
          OPW'(OP_LD), OPW'(OP_ADD), OPW'(OP_SUB),
          OPW'(OP_AND), OPW'(OP_OR), OPW'(OP_XOR): begin
            addr_d  = imm;
            read_d  = 1'b1;
            pc_d    = pc_q;
            state_d = ST_MEM;
          end
`ifdef CPU_MUL_EN
          OPW'(OP_MUL): begin
            addr_d  = imm;
            read_d  = 1'b1;
            pc_d    = pc_q;
            state_d = ST_MEM;
          end
`endif
          OPW'(OP_ST): begin
            addr_d  = imm;
            write_d = 1'b1;
            pc_d    = pc_q;
            state_d = ST_MEM;
          end
          OPW'(OP_JMP): pc_d = imm;
          OPW'(OP_JZ):  if (z_q) pc_d = imm;
          OPW'(OP_JC):  if (c_q) pc_d = imm;
          OPW'(OP_HLT): begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        // Address, request and store data stay put until the memory acknowledges.
        if (data_ready) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          pc_d    = pc_inc;
          state_d = ST_FETCH;
          if (!write_q) begin
            a_d = alu_result;
            z_d = (alu_result == '0);
            if (op_sets_c) c_d = alu_carry;
          end
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      a_q      <= '0;
      ir_q     <= '0;
      addr_q   <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      ir_q     <= ir_d;
      addr_q   <= addr_d;
      z_q      <= z_d;
      c_q      <= c_d;
      read_q   <= read_d;
      write_q  <= write_d;
      halted_q <= halted_d;
    end
  end

  assign out    = a_q;
  assign pc     = pc_q;
  assign addr   = addr_q;
  assign read   = read_q;
  assign write  = write_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed test of cpu_multicycle (WIDTH=16) running a small program from a bench-side
// instruction memory; covers MUL too when CPU_MUL_EN is defined.
module tb_cpu_multicycle;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] data;
  logic        data_ready;
  logic [15:0] out;
  logic [15:0] pc;
  logic [15:0] addr;
  logic        read;
  logic        write;
  logic        halted;

  logic [15:0] imem [0:63];
  int          n_checks;
  int          n_fail;

  assign instruction = imem[pc[5:0]];

  cpu_multicycle #(.WIDTH(16), .OPW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .data       (data),
    .data_ready (data_ready),
    .out        (out),
    .pc         (pc),
    .addr       (addr),
    .read       (read),
    .write      (write),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, actual, expected);
    end
  endtask

  // Runs one instruction starting from a negedge in FETCH; memory ops get data_ready
  // on their n-th MEM cycle. Ends on the negedge after completion.
  task automatic exec_op(input string name, input logic is_mem, input logic [15:0] d, input int n);
    repeat (2) @(posedge clk);
    if (is_mem) begin
      repeat (n - 1) @(posedge clk);
      @(negedge clk);
      data       = d;
      data_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    data_ready = 1'b0;
    $display("instr %-6s pc=0x%04h out=0x%04h", name, pc, out);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    data       = 16'h0000;
    data_ready = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    imem[6'h00] = 16'h1032;  // LDI 0x032
    imem[6'h01] = 16'h3100;  // ST  0x100
    imem[6'h02] = 16'h1FFF;  // LDI 0xFFF
    imem[6'h03] = 16'h4200;  // ADD [0x200]
    imem[6'h04] = 16'hB00A;  // JZ  0x00A
    imem[6'h0A] = 16'hC010;  // JC  0x010
    imem[6'h10] = 16'h1FFF;  // LDI 0xFFF
    imem[6'h11] = 16'h4200;  // ADD [0x200]
    imem[6'h12] = 16'hB00A;  // JZ  (not taken)
    imem[6'h13] = 16'hC00A;  // JC  (not taken)
    imem[6'h14] = 16'h5200;  // SUB [0x200]
    imem[6'h15] = 16'hC020;  // JC  0x020
    imem[6'h20] = 16'h6200;  // AND
    imem[6'h21] = 16'h8200;  // XOR
    imem[6'h22] = 16'h7200;  // OR
    imem[6'h23] = 16'h9000;  // unassigned -> NOP
`ifdef CPU_MUL_EN
    imem[6'h24] = 16'h1100;  // LDI 0x100
    imem[6'h25] = 16'hD200;  // MUL [0x200]
    imem[6'h26] = 16'hC030;  // JC  0x030
`else
    imem[6'h24] = 16'hD000;  // NOP without multiplier
    imem[6'h25] = 16'hC030;  // JC  0x030
`endif
    imem[6'h30] = 16'h3100;  // ST  0x100, interrupted by reset

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc, 16'h0000);
    check("rst_out", out, 16'h0000);
    check("rst_read", {15'b0, read}, 16'h0000);
    check("rst_write", {15'b0, write}, 16'h0000);
    check("rst_halted", {15'b0, halted}, 16'h0000);
    check("rst_addr", addr, 16'h0000);
    reset = 1'b1;

    exec_op("LDI", 1'b0, 16'h0000, 0);
    check("ldi_out", out, 16'h0032);
    check("ldi_pc", pc, 16'h0001);

    repeat (2) @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("st_write", {15'b0, write}, 16'h0001);
      check("st_read", {15'b0, read}, 16'h0000);
      check("st_addr", addr, 16'h0100);
      check("st_out", out, 16'h0032);
      check("st_pc_hold", pc, 16'h0001);
      if (i == 3) data_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    data_ready = 1'b0;
    $display("instr %-6s pc=0x%04h out=0x%04h", "ST", pc, out);
    check("st_done_write", {15'b0, write}, 16'h0000);
    check("st_done_pc", pc, 16'h0002);

    exec_op("LDI", 1'b0, 16'h0000, 0);
    check("ldi2_out", out, 16'h0FFF);
    exec_op("ADD", 1'b1, 16'hF001, 1);
    check("add_wrap_out", out, 16'h0000);
    check("add_read_clr", {15'b0, read}, 16'h0000);
    check("add_pc", pc, 16'h0004);
    exec_op("JZ", 1'b0, 16'h0000, 0);
    check("jz_taken", pc, 16'h000A);
    exec_op("JC", 1'b0, 16'h0000, 0);
    check("jc_taken", pc, 16'h0010);
    exec_op("LDI", 1'b0, 16'h0000, 0);
    exec_op("ADD", 1'b1, 16'h0005, 2);
    check("add_out", out, 16'h1004);
    exec_op("JZ", 1'b0, 16'h0000, 0);
    check("jz_not_taken", pc, 16'h0013);
    exec_op("JC", 1'b0, 16'h0000, 0);
    check("jc_not_taken", pc, 16'h0014);
    exec_op("SUB", 1'b1, 16'h1005, 1);
    check("sub_out", out, 16'hFFFF);
    exec_op("JC", 1'b0, 16'h0000, 0);
    check("sub_borrow_jc", pc, 16'h0020);
    exec_op("AND", 1'b1, 16'h0F0F, 1);
    check("and_out", out, 16'h0F0F);
    exec_op("XOR", 1'b1, 16'h0F0F, 1);
    check("xor_out", out, 16'h0000);
    exec_op("OR", 1'b1, 16'h00A0, 1);
    check("or_out", out, 16'h00A0);
    exec_op("NOP9", 1'b0, 16'h0000, 0);
    check("nop9_pc", pc, 16'h0024);
    check("nop9_out", out, 16'h00A0);
`ifdef CPU_MUL_EN
    exec_op("LDI", 1'b0, 16'h0000, 0);
    check("ldi3_out", out, 16'h0100);
    exec_op("MUL", 1'b1, 16'h0100, 1);
    check("mul_out", out, 16'h0000);
    exec_op("JC", 1'b0, 16'h0000, 0);
    check("mul_carry_jc", pc, 16'h0030);
`else
    exec_op("NOPD", 1'b0, 16'h0000, 0);
    check("nopd_pc", pc, 16'h0025);
    check("nopd_out", out, 16'h00A0);
    exec_op("JC", 1'b0, 16'h0000, 0);
    check("jc_logic_keeps_c", pc, 16'h0030);
`endif

    // Store that never completes: reset lands while write is pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("st2_write", {15'b0, write}, 16'h0001);
    imem[6'h00] = 16'h2007;  // LD [0x007]
    imem[6'h01] = 16'hF000;  // HLT
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_write", {15'b0, write}, 16'h0000);
    check("rst_mid_pc", pc, 16'h0000);
    check("rst_mid_out", out, 16'h0000);
    check("rst_mid_addr", addr, 16'h0000);
    reset      = 1'b1;
    data       = 16'h5555;
    data_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    data_ready = 1'b0;
    check("late_ready_read", {15'b0, read}, 16'h0001);
    check("late_ready_out", out, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    check("ld_wait_read", {15'b0, read}, 16'h0001);
    check("ld_wait_addr", addr, 16'h0007);
    check("ld_wait_pc", pc, 16'h0000);
    data       = 16'h0077;
    data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_ready = 1'b0;
    $display("instr %-6s pc=0x%04h out=0x%04h", "LD", pc, out);
    check("ld_out", out, 16'h0077);
    check("ld_pc", pc, 16'h0001);
    check("ld_read_clr", {15'b0, read}, 16'h0000);

    exec_op("HLT", 1'b0, 16'h0000, 0);
    check("hlt_halted", {15'b0, halted}, 16'h0001);
    check("hlt_pc", pc, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      imem[6'h01] = 16'h1000 | 16'($urandom_range(0, 4095));
      data        = 16'($urandom);
      data_ready  = i[0];
      @(posedge clk);
      @(negedge clk);
      check("halt_pc", pc, 16'h0001);
      check("halt_out", out, 16'h0077);
      check("halt_halted", {15'b0, halted}, 16'h0001);
      check("halt_rw", {14'b0, read, write}, 16'h0000);
    end
    data_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
